// File: rtl/stepdown_softstart_seq_if.sv
// Control/status bundle between converter enable/protection logic and the soft-start sequencer.
interface stepdown_softstart_seq_if #(
  parameter int unsigned CODE_W = 8
);
  logic              en;
  logic              ocp;
  logic [CODE_W-1:0] ramp_code;
  logic              drv_en;
  logic              ss_done;
  logic              fault;
  logic [1:0]        ss_state;

  modport master (
    output en,
    output ocp,
    input  ramp_code,
    input  drv_en,
    input  ss_done,
    input  fault,
    input  ss_state
  );

  modport slave (
    input  en,
    input  ocp,
    output ramp_code,
    output drv_en,
    output ss_done,
    output fault,
    output ss_state
  );
endinterface

// File: rtl/stepdown_softstart_seq.sv
// Soft-start sequencer: ramps the reference code one LSB per PRESCALE clocks to FINAL_CODE,
// gates the power-stage driver, and holds a timed hiccup after an over-current event.
module stepdown_softstart_seq #(
  parameter int unsigned CODE_W     = 8,
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned FINAL_CODE = 255,
  parameter int unsigned RETRY_CYC  = 1024
) (
  input logic                     clk,
  input logic                     rstb,
  input logic                     CELV,
  input logic                     CELG,
  input logic                     SUB,
  stepdown_softstart_seq_if.slave bus
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned RtW = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;

  localparam logic [PsW-1:0]    PsLast    = PsW'(PRESCALE - 1);
  localparam logic [RtW-1:0]    RtLast    = RtW'(RETRY_CYC - 1);
  localparam logic [CODE_W-1:0] CodeFinal = CODE_W'(FINAL_CODE);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRamp  = 2'b01,
    StDone  = 2'b10,
    StFault = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] code_inc;
  logic [PsW-1:0]    ps_q, ps_d;
  logic [RtW-1:0]    rt_q, rt_d;

  // Supply/substrate pins exist only for the cell netlist.
  logic unused_supply;
  assign unused_supply = ^{CELV, CELG, SUB};

  assign code_inc = code_q + 1'b1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      code_q  <= '0;
      ps_q    <= '0;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ps_q    <= ps_d;
      rt_q    <= rt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ps_d    = ps_q;
    rt_d    = rt_q;
    case (state_q)
      StIdle: begin
        code_d = '0;
        if (bus.en) begin
          state_d = StRamp;
          ps_d    = '0;
        end
      end
      StRamp, StDone: begin
        if (bus.ocp) begin
          // Protection wins over a simultaneous disable.
          state_d = StFault;
          code_d  = '0;
          ps_d    = '0;
          rt_d    = '0;
        end else if (!bus.en) begin
          state_d = StIdle;
          code_d  = '0;
          ps_d    = '0;
        end else if (state_q == StDone) begin
          code_d = CodeFinal;
        end else if (ps_q == PsLast) begin
          ps_d   = '0;
          code_d = code_inc;
          if (code_inc == CodeFinal) begin
            state_d = StDone;
          end
        end else begin
          ps_d = ps_q + 1'b1;
        end
      end
      StFault: begin
        code_d = '0;
        if (bus.ocp) begin
          rt_d = '0;
        end else if (rt_q == RtLast) begin
          state_d = StIdle;
          rt_d    = '0;
        end else begin
          rt_d = rt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        code_d  = '0;
        ps_d    = '0;
        rt_d    = '0;
      end
    endcase
  end

  always_comb begin
    bus.ramp_code = code_q;
    bus.drv_en    = (state_q == StRamp) || (state_q == StDone);
    bus.ss_done   = (state_q == StDone);
    bus.fault     = (state_q == StFault);
    bus.ss_state  = state_q;
  end

  a_code_max: assert property (@(posedge clk) disable iff (!rstb) code_q <= CodeFinal);
  a_done_code: assert property (@(posedge clk) disable iff (!rstb)
                                (state_q == StDone) |-> (code_q == CodeFinal));

endmodule

// File: tb/tb_stepdown_softstart_seq.sv
// Two sequencer instances (slow ramp, and PRESCALE=1) driven by shared enable/ocp and checked
// every cycle against a time-since-phase-entry model.
module tb_stepdown_softstart_seq;

  logic clk;
  logic rstb;
  logic en;
  logic ocp;
  logic chk_on;

  int n_checks;
  int n_fail;

  stepdown_softstart_seq_if #(.CODE_W(8)) bus_a ();
  stepdown_softstart_seq_if #(.CODE_W(8)) bus_b ();

  assign bus_a.en  = en;
  assign bus_a.ocp = ocp;
  assign bus_b.en  = en;
  assign bus_b.ocp = ocp;

  stepdown_softstart_seq #(
    .CODE_W    (8),
    .PRESCALE  (4),
    .FINAL_CODE(10),
    .RETRY_CYC (20)
  ) u_dut_a (
    .clk (clk),
    .rstb(rstb),
    .CELV(1'b1),
    .CELG(1'b0),
    .SUB (1'b0),
    .bus (bus_a)
  );

  stepdown_softstart_seq #(
    .CODE_W    (8),
    .PRESCALE  (1),
    .FINAL_CODE(3),
    .RETRY_CYC (5)
  ) u_dut_b (
    .clk (clk),
    .rstb(rstb),
    .CELV(1'b1),
    .CELG(1'b0),
    .SUB (1'b0),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each instance is off, on (ramping or done), or in hiccup; m_t counts edges spent
  // in the current phase, and every output follows from that by arithmetic.
  localparam int PhOff   = 0;
  localparam int PhOn    = 1;
  localparam int PhFault = 2;

  int m_phase[2];
  int m_t[2];

  function automatic int cfg_ps(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int cfg_fc(input int i);
    return (i == 0) ? 10 : 3;
  endfunction

  function automatic int cfg_rc(input int i);
    return (i == 0) ? 20 : 5;
  endfunction

  function automatic bit m_done(input int i);
    return (m_phase[i] == PhOn) && (m_t[i] >= cfg_fc(i) * cfg_ps(i));
  endfunction

  function automatic int exp_code(input int i);
    int c;
    if (m_phase[i] != PhOn) return 0;
    c = m_t[i] / cfg_ps(i);
    return (c > cfg_fc(i)) ? cfg_fc(i) : c;
  endfunction

  function automatic int exp_state(input int i);
    if (m_phase[i] == PhFault) return 3;
    if (m_phase[i] == PhOff) return 0;
    return m_done(i) ? 2 : 1;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = PhOff;
      m_t[i]     = 0;
    end
  end

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = PhOff;
        m_t[i]     = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_phase[i])
          PhOff: begin
            if (en) begin
              m_phase[i] = PhOn;
              m_t[i]     = 0;
            end
          end
          PhOn: begin
            if (ocp) begin
              m_phase[i] = PhFault;
              m_t[i]     = 0;
            end else if (!en) begin
              m_phase[i] = PhOff;
              m_t[i]     = 0;
            end else begin
              m_t[i] = m_t[i] + 1;
            end
          end
          default: begin
            if (ocp) begin
              m_t[i] = 0;
            end else begin
              m_t[i] = m_t[i] + 1;
              if (m_t[i] == cfg_rc(i)) begin
                m_phase[i] = PhOff;
                m_t[i]     = 0;
              end
            end
          end
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstb && chk_on) begin
      chk("a.ramp_code", int'(bus_a.ramp_code), exp_code(0));
      chk("a.drv_en", int'(bus_a.drv_en), int'(m_phase[0] == PhOn));
      chk("a.ss_done", int'(bus_a.ss_done), int'(m_done(0)));
      chk("a.fault", int'(bus_a.fault), int'(m_phase[0] == PhFault));
      chk("a.ss_state", int'(bus_a.ss_state), exp_state(0));
      chk("b.ramp_code", int'(bus_b.ramp_code), exp_code(1));
      chk("b.drv_en", int'(bus_b.drv_en), int'(m_phase[1] == PhOn));
      chk("b.ss_done", int'(bus_b.ss_done), int'(m_done(1)));
      chk("b.fault", int'(bus_b.fault), int'(m_phase[1] == PhFault));
      chk("b.ss_state", int'(bus_b.ss_state), exp_state(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".a.ramp_code"}, int'(bus_a.ramp_code), 0);
    chk({tag, ".a.drv_en"}, int'(bus_a.drv_en), 0);
    chk({tag, ".a.ss_done"}, int'(bus_a.ss_done), 0);
    chk({tag, ".a.fault"}, int'(bus_a.fault), 0);
    chk({tag, ".a.ss_state"}, int'(bus_a.ss_state), 0);
    chk({tag, ".b.ramp_code"}, int'(bus_b.ramp_code), 0);
    chk({tag, ".b.ss_state"}, int'(bus_b.ss_state), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_on   = 1'b0;
    rstb     = 1'b0;
    en       = 1'b0;
    ocp      = 1'b0;
    #12;
    chk_all_zero("reset");
    rstb = 1'b1;
    tick();
    tick();
    chk_on = 1'b1;

    // Ramp from enable; instance b finishes in three edges.
    en = 1'b1;
    tick();
    chk("t1.a.enter_state", int'(bus_a.ss_state), 1);
    chk("t1.a.enter_drv", int'(bus_a.drv_en), 1);
    tick();
    chk("t6.b.code1", int'(bus_b.ramp_code), 1);
    tick();
    chk("t6.b.code2", int'(bus_b.ramp_code), 2);
    chk("t6.b.not_done", int'(bus_b.ss_done), 0);
    tick();
    chk("t6.b.code3", int'(bus_b.ramp_code), 3);
    chk("t6.b.done", int'(bus_b.ss_done), 1);
    chk("t6.b.state", int'(bus_b.ss_state), 2);
    chk("t1.a.code_3edges", int'(bus_a.ramp_code), 0);
    tick();
    chk("t1.a.first_step", int'(bus_a.ramp_code), 1);
    repeat (35) tick();
    chk("t1.a.code_39", int'(bus_a.ramp_code), 9);
    chk("t1.a.not_done_39", int'(bus_a.ss_done), 0);
    tick();
    chk("t1.a.code_40", int'(bus_a.ramp_code), 10);
    chk("t1.a.done_40", int'(bus_a.ss_done), 1);
    chk("t1.a.state_40", int'(bus_a.ss_state), 2);

    // Disable from DONE, then a full ramp again.
    en = 1'b0;
    tick();
    chk("t3.a.state_off", int'(bus_a.ss_state), 0);
    chk("t3.a.code_off", int'(bus_a.ramp_code), 0);
    chk("t3.a.drv_off", int'(bus_a.drv_en), 0);
    en = 1'b1;
    tick();
    chk("t3.a.reenter", int'(bus_a.ss_state), 1);
    repeat (39) tick();
    chk("t3.a.code_39", int'(bus_a.ramp_code), 9);
    tick();
    chk("t3.a.done_40", int'(bus_a.ss_state), 2);

    // Over-current at code 5, then hiccup and automatic restart.
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    repeat (20) tick();
    chk("t2.a.code5", int'(bus_a.ramp_code), 5);
    ocp = 1'b1;
    tick();
    ocp = 1'b0;
    chk("t2.a.fault", int'(bus_a.fault), 1);
    chk("t2.a.state", int'(bus_a.ss_state), 3);
    chk("t2.a.code", int'(bus_a.ramp_code), 0);
    chk("t2.a.drv", int'(bus_a.drv_en), 0);
    repeat (19) tick();
    chk("t2.a.fault_19", int'(bus_a.fault), 1);
    tick();
    chk("t2.a.fault_20", int'(bus_a.fault), 0);
    chk("t2.a.idle_20", int'(bus_a.ss_state), 0);
    tick();
    chk("t2.a.restart", int'(bus_a.ss_state), 1);
    chk("t2.a.restart_code", int'(bus_a.ramp_code), 0);

    // Simultaneous ocp and disable, then a hold restart at retry count 15.
    tick();
    tick();
    en  = 1'b0;
    ocp = 1'b1;
    tick();
    chk("t5.a.fault_not_idle", int'(bus_a.ss_state), 3);
    ocp = 1'b0;
    en  = 1'b1;
    repeat (15) tick();
    ocp = 1'b1;
    tick();
    ocp = 1'b0;
    repeat (19) tick();
    chk("t5.a.hold_19", int'(bus_a.ss_state), 3);
    tick();
    chk("t5.a.hold_20", int'(bus_a.ss_state), 0);
    tick();
    chk("t5.a.ramp_again", int'(bus_a.ss_state), 1);

    // Asynchronous reset mid-ramp.
    repeat (28) tick();
    chk("t4.a.code7", int'(bus_a.ramp_code), 7);
    #2;
    rstb = 1'b0;
    #1;
    chk_all_zero("t4.async");
    @(negedge clk);
    #2;
    rstb = 1'b1;
    tick();
    chk("t4.a.ramp_after_release", int'(bus_a.ss_state), 1);

    // Random enable/ocp/reset traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) en = ~en;
      ocp = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rstb = 1'b0;
        #2;
        rstb = 1'b1;
      end
      tick();
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
